// File: rtl/rand_inj_pkg.sv
// ----------------------------------------------------------------------------
// rand_inj_pkg
// Shared definitions for the random-valid injector:
//   - FSM state encoding
//   - 8-bit LFSR tap mask (taps 7,5,4,3) and zero-seed substitute
//   - helpers for one LFSR step and seed sanitising
// ----------------------------------------------------------------------------
package rand_inj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_OFFER = 2'd2
    } inj_state_t;

    // Feedback taps at bit positions 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_TAP_MASK = 8'b1011_1000;

    // An all-zero LFSR would lock up, so a zero seed is replaced by this.
    localparam logic [7:0] LFSR_ZERO_SEED = 8'h01;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAP_MASK)};
    endfunction

    function automatic logic [7:0] seed_fixup(input logic [7:0] seed);
        return (seed == 8'h00) ? LFSR_ZERO_SEED : seed;
    endfunction

endpackage

// File: rtl/lfsr8_step.sv
// ----------------------------------------------------------------------------
// lfsr8_step
// 8-bit Fibonacci LFSR register that steps only when asked.
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-high; loads the (sanitised) seed
//   seed    - seed value, sampled only while reset is high
//   advance - step the LFSR by one position on this edge
//   value   - current LFSR contents
// ----------------------------------------------------------------------------
module lfsr8_step
    import rand_inj_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] seed,
    input  logic       advance,
    output logic [7:0] value
);

    always_ff @(posedge clock) begin
        if (reset) begin
            value <= seed_fixup(seed);
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/rand_valid_injector.sv
// ----------------------------------------------------------------------------
// rand_valid_injector
// Single-entry valid/ready stage that holds each accepted request for a
// pseudo-random number of cycles (0..MAX_DELAY) before offering it
// downstream. A sticky flag reports a downstream stall of TIMEOUT cycles.
// Parameters:
//   DATA_W    - payload width
//   MAX_DELAY - largest inserted delay in cycles (0..255)
//   TIMEOUT   - unacknowledged offer cycles before timeout sets (1..65535)
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   dynamic_seed   - LFSR seed, sampled only while reset is high
//   in_valid/ready - upstream handshake, in_data payload
//   out_valid/ready- downstream handshake, out_data registered payload
//   busy           - high whenever the FSM is not idle
//   timeout        - sticky stall-error flag, cleared only by reset
// ----------------------------------------------------------------------------
module rand_valid_injector
    import rand_inj_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_DELAY = 20,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        dynamic_seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              timeout
);

    // Modulus held in 9 bits so MAX_DELAY = 255 (modulus 256) stays exact.
    localparam logic [8:0]  DELAY_MOD   = 9'(MAX_DELAY + 1);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);

    inj_state_t        state;
    inj_state_t        state_nxt;
    logic              accept;
    logic [7:0]        lfsr_val;
    logic [7:0]        target_nxt;
    logic [7:0]        target;
    logic [7:0]        delay_cnt;
    logic [15:0]       wait_cnt;
    logic [DATA_W-1:0] data_q;
    logic              timeout_q;
    logic              offer_entry;
    logic              stall_cycle;

    // ------------------------------------------------------------------
    // LFSR: advances only on an accepted request.
    // ------------------------------------------------------------------
    lfsr8_step u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .seed    (dynamic_seed),
        .advance (accept),
        .value   (lfsr_val)
    );

    assign target_nxt = 8'({1'b0, lfsr_val} % DELAY_MOD);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;

        unique case (state)
            ST_IDLE: begin
                // Held low during reset so nothing upstream sees a
                // handshake that the reset edge would then discard.
                in_ready = ~reset;
                busy     = 1'b0;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = (target_nxt == 8'd0) ? ST_OFFER : ST_DELAY;
                end
            end
            ST_DELAY: begin
                // delay_cnt starts at 0, so this exits after exactly
                // target cycles in DELAY.
                if (delay_cnt == target - 8'd1) begin
                    state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign offer_entry = (state != ST_OFFER) && (state_nxt == ST_OFFER);
    assign stall_cycle = (state == ST_OFFER) && !out_ready;

    // ------------------------------------------------------------------
    // Payload and target capture (only on accept)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
            target <= '0;
        end else if (accept) begin
            data_q <= in_data;
            target <= target_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Delay counter: runs only while staying in DELAY, zero otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            delay_cnt <= '0;
        end else if ((state == ST_DELAY) && (state_nxt == ST_DELAY)) begin
            delay_cnt <= delay_cnt + 8'd1;
        end else begin
            delay_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Stall watchdog: counts OFFER cycles without out_ready, saturating
    // at TIMEOUT. The flag sets on the edge the count reaches TIMEOUT and
    // is sticky; the offer itself keeps going.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (offer_entry) begin
            wait_cnt <= '0;
        end else if (stall_cycle && (wait_cnt != TIMEOUT_LIM)) begin
            wait_cnt <= wait_cnt + 16'd1;
            if (wait_cnt == TIMEOUT_LIM - 16'd1) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign out_data = data_q;
    assign timeout  = timeout_q;

endmodule

// File: doc/rand_valid_injector.md
RAND_VALID_INJECTOR -- requirements
Module: rand_valid_injector

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width.
REQ-002 SHALL have parameter MAX_DELAY, default 20, largest inserted delay in cycles; legal range 0..255.
REQ-003 SHALL have parameter TIMEOUT, default 255, count of unacknowledged offer cycles before the timeout flag sets; legal range 1..65535.
REQ-004 SHALL have port clock, input, 1 bit: sole clock, all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port dynamic_seed, input, 8 bits: LFSR seed, sampled only while reset is high.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream request present.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-009 SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-010 SHALL have port out_valid, output, 1 bit: request offered downstream.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-012 SHALL have port out_data, output, DATA_W bits: registered payload.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port timeout, output, 1 bit: sticky stall-error flag.

Function
REQ-015 SHALL implement an FSM with states IDLE, DELAY and OFFER.
- in_ready = (state == IDLE).
- out_valid = (state == OFFER).
- All outputs registered or decoded from state only; no combinational in-to-out path.
REQ-016 In IDLE with in_valid high, the block SHALL:
- capture in_data into out_data;
- set target = lfsr % (MAX_DELAY+1), computed at 8 bits;
- advance the LFSR one step;
- go to OFFER if target == 0, else DELAY.
REQ-017 The LFSR SHALL step as lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}, and only on accepts.
REQ-018 In DELAY, an 8-bit counter SHALL count up from 0 and move to OFFER when count == target-1, giving exactly target DELAY cycles.
REQ-019 out_valid SHALL first assert target+1 cycles after the accept edge.
REQ-020 In OFFER, out_data and out_valid SHALL hold stable until out_ready is high, then the FSM SHALL return to IDLE on that edge.
REQ-021 Throughput SHALL be at most one request per target+2 cycles, with no bypass and no second buffer.
REQ-022 in_valid while not in IDLE SHALL be ignored: no capture and no LFSR step.
REQ-023 A wait counter SHALL clear on OFFER entry and increment each OFFER cycle with out_ready low, saturating at TIMEOUT.
REQ-024 timeout SHALL set on the edge where the wait counter reaches TIMEOUT and SHALL stay set until reset.
REQ-025 The request SHALL NOT be dropped on timeout; the offer continues.
REQ-026 out_ready high in the first OFFER cycle SHALL complete the transfer with 0 wait and no timeout.

Reset
REQ-027 With reset high, on the clock edge the block SHALL set:
- state IDLE; lfsr = dynamic_seed, or 8'h01 if dynamic_seed == 0;
- counters 0; out_data 0; timeout 0.
REQ-028 Reset asserted mid-DELAY or mid-OFFER SHALL discard the pending request, so out_valid is low the cycle after the reset edge.
REQ-029 While reset is high, in_ready SHALL read 0.

Structure
REQ-030 The state encoding, tap positions {7,5,4,3} and the zero-seed substitute 8'h01 SHALL live in a shared package, rand_inj_pkg.
REQ-031 The LFSR register and step logic SHALL be one sub-module, lfsr8_step, with ports clock, reset, seed, advance and value.
REQ-032 The FSM, counters and payload register SHALL stay in rand_valid_injector.

Verification
REQ-033 SHALL cover: seed 8'h01, in_valid pulse, data 32'hA5A5_0001, out_ready=1 -> target 1, out_valid high exactly 2 cycles after accept, out_data 32'hA5A5_0001.
REQ-034 SHALL cover: seed 8'hDA, two back-to-back requests, out_ready=1 -> targets 8 then 13 (next lfsr 8'hB5), out_valid at accept+9 and accept+14.
REQ-035 SHALL cover: seed 8'h00 -> behaves as seed 8'h01, target 1.
REQ-036 SHALL cover: TIMEOUT=4, out_ready held low -> timeout rises after 4 offer cycles, out_valid stays high, out_ready=1 then completes the transfer and timeout stays 1.
REQ-037 SHALL cover: reset asserted in DELAY -> next cycle out_valid=0, busy=0, and in_ready=1 after reset drops.
REQ-038 SHALL cover: in_valid toggled during DELAY/OFFER -> no extra capture, and LFSR sequence unchanged against the reference model.
